// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a byte FIFO and a status word.
// Raw PS/2 lines are synchronized, the clock is debounced by a run-length
// filter, and each falling edge of the filtered clock clocks one frame bit.
// Good frames go into the FIFO. Bad frames set a sticky parity error.
// Overflows set a sticky ovf flag.
// Optional macro PS2_RX_TIMEOUT_EN adds an inter-bit watchdog. The watchdog
// aborts a stalled frame and sets a sticky tmo flag.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          reg_dat_re,
    output logic [31:0]                   reg_dat_do,
    output logic                          reg_dat_wait,
    output logic                          irq,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------
    // Synchronizers (idle-high lines, so reset to 1)
    // ------------------------------------------------------------------
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    // Two-flop synchronizers for both raw PS/2 lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter: the counter tracks how many consecutive samples have
    // disagreed with the current filtered level. The level flips on the
    // FILTER_LEN-th such sample. Any agreeing sample restarts the run.
    // ------------------------------------------------------------------
    logic          flt_clk_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flt_flip;
    logic          strobe;

    assign flt_flip = (clk_s2_q != flt_clk_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
    // A bit strobe is the filtered clock going 1->0 in this cycle
    assign strobe   = flt_flip && flt_clk_q;

    // Run-length debounce of the synchronized PS/2 clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flt_clk_q <= 1'b1;
            flt_cnt_q <= '0;
        end else if (clk_s2_q == flt_clk_q) begin
            flt_cnt_q <= '0;
        end else if (flt_flip) begin
            flt_clk_q <= clk_s2_q;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Watchdog (optional)
    // ------------------------------------------------------------------
    logic   state_idle;
    logic   tmo_hit;
    logic   tmo_flag;
    logic   pop;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q;

    // Hits on the TIMEOUT_CYCLES-th cycle with no strobe while mid-frame
    assign tmo_hit  = !state_idle && !strobe && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_flag = tmo_q;

    // Cycles since the last bit strobe, held at zero while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt_q <= '0;
        else if (state_idle || strobe || tmo_hit)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end

    // Sticky timeout flag; a new timeout wins over a clearing pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_q <= 1'b0;
        else
            tmo_q <= tmo_hit || (tmo_q && !pop);
    end
`else
    assign tmo_hit  = 1'b0;
    // No watchdog: the tmo status bit can never assert
    assign tmo_flag = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic       frame_end;
    logic       frame_good;
    logic       frame_bad;

    assign state_idle = (state_q == S_IDLE);
    assign frame_end  = strobe && (state_q == S_STOP);
    // Good: stop bit high and odd parity over data+parity
    assign frame_good = frame_end && dat_s2_q && (^{shift_q, par_q});
    assign frame_bad  = frame_end && !frame_good;

    // Start / 8 data / parity / stop sequencing, advanced only by strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else if (tmo_hit) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
        end else if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    shift_q <= {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_q   <= S_PARITY;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_q   <= dat_s2_q;
                    state_q <= S_STOP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          empty, full, push, ovf_set;
    logic          perr_q, ovf_q;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = reg_dat_re && !empty;
    // At full a simultaneous pop frees the slot this push takes
    assign push    = frame_good && (!full || pop);
    assign ovf_set = frame_good && full && !pop;

    // Storage array, written on push only
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= shift_q;
    end

    // Pointers wrap naturally at power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Sticky error flags: cleared by a pop, but a same-cycle set wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            perr_q <= frame_bad || (perr_q && !pop);
            ovf_q  <= ovf_set   || (ovf_q  && !pop);
        end
    end

    // ------------------------------------------------------------------
    // Register interface
    // ------------------------------------------------------------------
    assign reg_dat_do   = empty ? 32'hFFFF_FFFF
                                : {21'd0, tmo_flag, ovf_q, perr_q, mem_q[rd_ptr_q]};
    assign reg_dat_wait = 1'b0;
    assign irq          = !empty;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed frames followed by random traffic. The
// expected results come from a queue-based model of the receive FIFO and its
// status flags. Define PS2_RX_TIMEOUT_EN to also exercise the watchdog.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int HALF  = 20;   // PS/2 half period in clk cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk, ps2_data, reg_dat_re;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait, irq;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;

    // model state
    logic [7:0] mq[$];
    logic       m_perr = 1'b0, m_ovf = 1'b0, m_tmo = 1'b0;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(8), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .reg_dat_re(reg_dat_re), .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait),
        .irq(irq), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "bench hang");
    end

    function automatic logic [31:0] exp_do();
        if (mq.size() == 0) return 32'hFFFF_FFFF;
        return {21'd0, m_tmo, m_ovf, m_perr, mq[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic good);
        if (!good) m_perr = 1'b1;
        else if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_clks(2 * HALF);
        model_frame(d, !bad_par && !bad_stop);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "/do"},    reg_dat_do, exp_do());
        chk({tag, "/level"}, {29'd0, fifo_level}, 32'(mq.size()));
        chk({tag, "/irq"},   {31'd0, irq}, {31'd0, mq.size() != 0});
    endtask

    task automatic do_read(input string tag);
        @(negedge clk);
        chk(tag, reg_dat_do, exp_do());
        reg_dat_re = 1'b1;
        @(negedge clk);
        reg_dat_re = 1'b0;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_perr = 1'b0;
            m_ovf  = 1'b0;
            m_tmo  = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; reg_dat_re = 1'b0;
        wait_clks(4);
        chk("rst/do", reg_dat_do, 32'hFFFF_FFFF);
        chk("rst/level", {29'd0, fifo_level}, 32'd0);
        chk("rst/irq", {31'd0, irq}, 32'd0);
        chk("rst/wait", {31'd0, reg_dat_wait}, 32'd0);
        reset = 1'b0;
        wait_clks(4);

        // single good frame, then read it back
        send_frame(8'h1C, 1'b0, 1'b0);
        check_state("f1c");
        chk("f1c/lit", reg_dat_do, 32'h0000_001C);
        do_read("f1c/read");
        check_state("f1c/empty");

        // read on empty is ignored
        do_read("empty/read");
        check_state("empty/after");

        // bad parity then good frame: perr shows on next head
        send_frame(8'h1C, 1'b1, 1'b0);
        check_state("badpar");
        send_frame(8'h32, 1'b0, 1'b0);
        chk("perr/lit", reg_dat_do, 32'h0000_0132);
        do_read("perr/read");

        // overflow at depth 4
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        check_state("ovf");
        chk("ovf/lit", {29'd0, fifo_level}, 32'd4);
        chk("ovf/lit_do", reg_dat_do, 32'h0000_0201);
        for (int i = 0; i < 4; i++) do_read("ovf/read");
        check_state("ovf/drained");

        // glitches shorter than the filter produce no strobe
        ps2_data = 1'b0;
        ps2_clk = 1'b0; wait_clks(3); ps2_clk = 1'b1; wait_clks(30);
        ps2_clk = 1'b0; wait_clks(7); ps2_clk = 1'b1; wait_clks(30);
        ps2_data = 1'b1; wait_clks(HALF);
        check_state("glitch");
        send_frame(8'hA5, 1'b0, 1'b0);
        do_read("glitch/frame");

`ifdef PS2_RX_TIMEOUT_EN
        // stall after 4 data bits; watchdog returns to IDLE and flags tmo
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(1200);
        m_tmo = 1'b1;
        check_state("tmo/idle");
        send_frame(8'hAA, 1'b0, 1'b0);
        chk("tmo/lit", reg_dat_do, 32'h0000_04AA);
        do_read("tmo/read");
`endif

        // reset mid-frame discards everything
        send_frame(8'h11, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        reset = 1'b1;
        #1;
        mq.delete(); m_perr = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
        chk("midrst/do", reg_dat_do, 32'hFFFF_FFFF);
        chk("midrst/level", {29'd0, fifo_level}, 32'd0);
        chk("midrst/irq", {31'd0, irq}, 32'd0);
        ps2_data = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(5);
        send_frame(8'h55, 1'b0, 1'b0);
        chk("midrst/lit", reg_dat_do, 32'h0000_0055);
        check_state("midrst/frame");
        do_read("midrst/read");

        // random traffic
        for (int n = 0; n < 24; n++) begin
            int act;
            act = int'($urandom_range(0, 3));
            if (act == 0) begin
                do_read("rnd/read");
            end else begin
                logic [7:0] d;
                logic bp, bs;
                d  = 8'($urandom);
                bp = ($urandom_range(0, 3) == 0);
                bs = ($urandom_range(0, 7) == 0);
                send_frame(d, bp, bs);
            end
            check_state("rnd");
        end
        while (mq.size() != 0) do_read("rnd/drain");
        check_state("rnd/end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
